// File: rtl/div_pkg.sv
// Shared constants and types for the 32-bit restoring divider.
// Widths, iteration bound and FSM state encoding.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int CNT_W     = 6;
  localparam int LAST_ITER = 31;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_t;

endpackage

// File: rtl/sub_33_bit.sv
// 33-bit trial subtractor for the restoring step.
// difference = a - b, formed as a + ~b + 1.
module sub_33_bit (
  input  logic [32:0] a,
  input  logic [32:0] b,
  output logic [32:0] difference
);

  assign difference = a + ~b + 33'd1;

endmodule

// File: rtl/restoring_divider_32.sv
// 32-bit unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero answers in one cycle without entering RUN.
module restoring_divider_32
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_ITER);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_t       state, state_d;
  logic [DIV_W-1:0] q_reg, q_d;
  logic [DIV_W-1:0] r_reg, r_d;
  logic [DIV_W-1:0] dsr_reg, dsr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [DIV_W-1:0] quot_d, rem_d;
  logic             dbz_d, done_d;

  logic [DIV_W:0]   r_shift;
  logic [DIV_W:0]   trial;
  logic [DIV_W-1:0] q_step, r_step;

  assign r_shift = {r_reg, q_reg[DIV_W-1]};

  sub_33_bit u_sub (
    .a          (r_shift),
    .b          ({1'b0, dsr_reg}),
    .difference (trial)
  );

  // Negative trial result means restore the shifted remainder.
  assign q_step = {q_reg[DIV_W-2:0], ~trial[DIV_W]};
  assign r_step = trial[DIV_W] ? r_shift[DIV_W-1:0]
                               : trial[DIV_W-1:0];

  assign busy = (state == RUN);

  always_comb begin
    state_d = state;
    q_d     = q_reg;
    r_d     = r_reg;
    dsr_d   = dsr_reg;
    cnt_d   = cnt;
    quot_d  = quotient;
    rem_d   = remainder;
    dbz_d   = div_by_zero;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            state_d = RUN;
            q_d     = dividend;
            r_d     = '0;
            dsr_d   = divisor;
            cnt_d   = '0;
          end else begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt + CNT_ONE;
        if (cnt == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          quot_d  = q_step;
          rem_d   = r_step;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      q_reg       <= '0;
      r_reg       <= '0;
      dsr_reg     <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      q_reg       <= q_d;
      r_reg       <= r_d;
      dsr_reg     <= dsr_d;
      cnt         <= cnt_d;
      quotient    <= quot_d;
      remainder   <= rem_d;
      div_by_zero <= dbz_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_restoring_divider_32.sv
// Directed and random bench for restoring_divider_32.
// Expected results are queued at start and checked at done.
module tb_restoring_divider_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          cyc;
    int          busy;
  } exp_t;

  exp_t sb[$];

  restoring_divider_32 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_done: got done=1 want no pulse");
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", 64'(quotient), 64'(e.q));
          chk("remainder", 64'(remainder), 64'(e.r));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.z));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
          if (e.b != 0) begin
            chk("identity", 64'(quotient) * 64'(e.b) + 64'(remainder),
                64'(e.a));
            chk("rem_lt_div", 64'(remainder < e.b), 64'd1);
          end
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at posedge+1; the following edge samples start.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.z = 1'b1;
      e.cyc = cyc + 1;
      e.busy = 0;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
      e.cyc = cyc + 33;
      e.busy = 32;
    end
    sb.push_back(e);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    assert (done === 1'b1) else begin
      n_err++;
      $error("FAIL done_timeout: got done=%b want 1", done);
    end
  endtask

  function automatic logic [31:0] pick(input int sel);
    logic [31:0] v;
    unique case (sel)
      0: v = 32'h0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'($urandom_range(1, 300));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    start_op(32'd100, 32'd7);
    wait_done();
    @(posedge clk);
    #1;

    start_op(32'hFFFF_FFFF, 32'd1);
    wait_done();
    start_op(32'd3, 32'd10);
    wait_done();
    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    @(posedge clk);
    #1;

    start_op(32'd5, 32'd0);
    wait_done();
    @(posedge clk);
    #1;

    start_op(32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    dividend = 32'd9;
    divisor = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    start_op(32'd9, 32'd3);
    wait_done();
    @(posedge clk);
    #1;

    start_op(32'd12345, 32'd7);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_quotient", 64'(quotient), 64'd0);
    chk("mid_rst_remainder", 64'(remainder), 64'd0);
    chk("mid_rst_dbz", 64'(div_by_zero), 64'd0);
    #3;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    start_op(32'd1000, 32'd33);
    wait_done();

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = pick($urandom_range(0, 3));
      b = pick($urandom_range(0, 7));
      start_op(a, b);
      wait_done();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
